// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stage controller: sequencer states,
// stage-register indices and the default memory-wait timeout.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } pctrl_state_t;

  // Bit positions of the stage registers in a packed enable vector
  localparam int STG_PC    = 0;
  localparam int STG_IFID  = 1;
  localparam int STG_IDEX  = 2;
  localparam int STG_EXMEM = 3;
  localparam int STG_MEMWB = 4;
  localparam int NUM_STG   = 5;

  localparam int DEF_MEM_TIMEOUT = 255;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for stall/flush statistics; sticks at all-ones.
module sat_counter
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  // Count up on inc, hold once every bit is set
  always_ff @(posedge Clock) begin
    if (Reset || clr) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipeline_stage_ctrl.sv
// Pipeline sequencer: derives per-stage ClockEnables and bubble flushes from
// hazard, branch, data-memory handshake and halt inputs, tracks memory-wait
// timeout and halt state, and keeps saturating stall/flush statistics.
module pipeline_stage_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Tick,
  input  logic [REG_ADDR_W-1:0] id_rs_addr,
  input  logic [REG_ADDR_W-1:0] id_rt_addr,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  input  logic                  halt_req,
  input  logic                  resume,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  idex_en,
  output logic                  exmem_en,
  output logic                  memwb_en,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  memwb_flush,
  output logic                  halted,
  output logic                  mem_err,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  // Wide enough to hold MEM_TIMEOUT itself
  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  pctrl_state_t        r_state, w_state_nxt;
  logic [WAIT_W-1:0]   r_wait, w_wait_nxt, w_wait_inc;
  logic                r_mem_err, w_mem_err_nxt;
  logic [NUM_STG-1:0]  w_en;
  logic                w_ifid_flush, w_idex_flush, w_memwb_flush;
  logic                w_load_use, w_mem_stall;
  logic                w_stall_inc, w_flush_inc;

  // Load in EX feeding a register that ID reads; r0 never creates a hazard
  assign w_load_use = ex_mem_read && (ex_rd_addr != '0) &&
                      ((id_uses_rs && (id_rs_addr == ex_rd_addr)) ||
                       (id_uses_rt && (id_rt_addr == ex_rd_addr)));
  assign w_mem_stall = mem_req && !mem_ready;
  assign w_wait_inc  = r_wait + WAIT_W'(1);

  // Next-state, enables and flushes; everything idles under Reset or !Tick
  always_comb begin
    w_state_nxt   = r_state;
    w_wait_nxt    = r_wait;
    w_mem_err_nxt = r_mem_err;
    w_en          = '0;
    w_ifid_flush  = 1'b0;
    w_idex_flush  = 1'b0;
    w_memwb_flush = 1'b0;
    w_stall_inc   = 1'b0;
    w_flush_inc   = 1'b0;
    if (!Reset && Tick) begin
      case (r_state)
        RUN, MEM_WAIT: begin
          if (halt_req) begin
            w_state_nxt = HALT;
          end else if (w_mem_stall) begin
            // Freeze upstream, drain a bubble into WB while memory is busy
            w_en[STG_MEMWB] = 1'b1;
            w_memwb_flush   = 1'b1;
            w_stall_inc     = 1'b1;
            w_wait_nxt      = w_wait_inc;
            if (w_wait_inc >= WAIT_W'(MEM_TIMEOUT)) begin
              w_mem_err_nxt = 1'b1;
              w_state_nxt   = HALT;
            end else begin
              w_state_nxt   = MEM_WAIT;
            end
          end else begin
            w_wait_nxt  = '0;
            w_state_nxt = RUN;
            if (ex_branch_taken) begin
              // Branch squashes both younger instructions, so it wins over load-use
              w_en         = '1;
              w_ifid_flush = 1'b1;
              w_idex_flush = 1'b1;
              w_flush_inc  = 1'b1;
            end else if (w_load_use) begin
              w_en[STG_IDEX]  = 1'b1;
              w_en[STG_EXMEM] = 1'b1;
              w_en[STG_MEMWB] = 1'b1;
              w_idex_flush    = 1'b1;
              w_stall_inc     = 1'b1;
            end else begin
              w_en = '1;
            end
          end
        end
        HALT: begin
          if (resume && !r_mem_err) begin
            w_state_nxt = RUN;
            w_wait_nxt  = '0;
          end
        end
        default: begin
          w_state_nxt = RUN;
          w_wait_nxt  = '0;
        end
      endcase
    end
  end

  // State, wait counter and sticky timeout flag
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state   <= RUN;
      r_wait    <= '0;
      r_mem_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wait    <= w_wait_nxt;
      r_mem_err <= w_mem_err_nxt;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .Clock (Clock),
    .Reset (Reset),
    .inc   (w_stall_inc),
    .clr   (1'b0),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .Clock (Clock),
    .Reset (Reset),
    .inc   (w_flush_inc),
    .clr   (1'b0),
    .count (flush_cnt)
  );

  assign pc_en       = w_en[STG_PC];
  assign ifid_en     = w_en[STG_IFID];
  assign idex_en     = w_en[STG_IDEX];
  assign exmem_en    = w_en[STG_EXMEM];
  assign memwb_en    = w_en[STG_MEMWB];
  assign ifid_flush  = w_ifid_flush;
  assign idex_flush  = w_idex_flush;
  assign memwb_flush = w_memwb_flush;
  assign halted      = (r_state == HALT);
  assign mem_err     = r_mem_err;

endmodule
